// File: rtl/audio_pkg.sv
// ============================================================================
// audio_pkg : shared state encoding, note-code tables and note_div helpers
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package audio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUSIC = 2'd1,
      SFX   = 2'd2
   } state_t;

   localparam int     NOTE_W = 6;
   localparam int     DIV_W  = 22;
   localparam longint CLK_HZ = 64'd100_000_000;

   typedef logic [NOTE_W-1:0] note_t;
   typedef logic [63:0][DIV_W-1:0] div_lut_t;

   // Code 1 is A1 (55 Hz); each code above it is one semitone higher. Code 0 is a rest.
   function automatic logic [DIV_W-1:0] note_div_of(input int code);
      longint base_chz;
      longint f_chz;
      longint div;
      if (code == 0) return '0;
      case ((code - 1) % 12)
         0:       base_chz = 5500;
         1:       base_chz = 5827;
         2:       base_chz = 6174;
         3:       base_chz = 6541;
         4:       base_chz = 6930;
         5:       base_chz = 7342;
         6:       base_chz = 7778;
         7:       base_chz = 8241;
         8:       base_chz = 8731;
         9:       base_chz = 9250;
         10:      base_chz = 9800;
         default: base_chz = 10383;
      endcase
      f_chz = base_chz << ((code - 1) / 12);
      div   = (CLK_HZ * 100) / (2 * f_chz) - 1;
      return div[DIV_W-1:0];
   endfunction

   function automatic div_lut_t build_div_lut();
      div_lut_t lut;
      for (int c = 0; c < 64; c++) lut[c] = note_div_of(c);
      return lut;
   endfunction

   localparam div_lut_t NOTE_DIV_LUT = build_div_lut();

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam note_t MEL_ROM [64] = '{
      37,  0, 40, 37, 44, 42, 40, 39,
      37,  0, 35, 37, 39, 40, 42, 44,
      45, 44, 42, 40, 39, 37, 35,  0,
      33, 35, 37, 39, 40, 39, 37,  0,
      44,  0, 44, 45, 47, 45, 44, 42,
      40,  0, 40, 42, 44, 42, 40, 39,
      37, 39, 40, 42, 44,  0, 40, 37,
      37,  0, 33, 35, 37,  0,  0,  0
   };

   // 0: line clear, 1: drop, 2: game over, 3: spare alert
   localparam note_t SFX_ROM [4][8] = '{
      '{37, 41, 44, 49, 41, 44, 49, 53},
      '{49, 52, 45, 40, 37, 33,  0,  0},
      '{25, 28, 24, 23, 22, 21, 20,  0},
      '{61,  0, 61,  0, 61,  0, 61,  0}
   };

endpackage

`default_nettype wire

// File: rtl/music_sequencer_step_timer.sv
// ============================================================================
// step_timer : terminal-count counter with enable and synchronous clear
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module step_timer #(
   parameter int CYCLES = 16,
   parameter int WIDTH  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   assign tc = en && (count == WIDTH'(CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= tc ? '0 : count + 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/music_sequencer.sv
// ============================================================================
// music_sequencer : melody stepper with sound-effect override for the note generator
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module music_sequencer #(
   parameter int          BEAT_CYCLES = 12_500_000,
   parameter int          SFX_DIV     = 4,
   parameter int          MEL_LEN     = 64,
   parameter int          SFX_LEN     = 8,
   parameter logic [15:0] AMP         = 16'h2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        play,
   input  logic        sfx_req,
   input  logic [1:0]  sfx_id,
   input  logic        mute,
   output logic [21:0] note_div,
   output logic [15:0] amplitude,
   output logic        sfx_busy,
   output logic        beat_tick,
   output logic [5:0]  mel_idx
);

   import audio_pkg::*;

   localparam int STEP_CYCLES = BEAT_CYCLES / SFX_DIV;
   localparam int BEAT_W      = cnt_width(BEAT_CYCLES);
   localparam int STEP_W      = cnt_width(STEP_CYCLES);
   localparam int BEAT_GAP    = BEAT_CYCLES / 8;
   localparam int STEP_GAP    = STEP_CYCLES / 8;

   state_t              state;
   logic [2:0]          sfx_step;
   logic [1:0]          sfx_id_l;
   logic [BEAT_W-1:0]   beat_count;
   logic [STEP_W-1:0]   step_count;
   logic                beat_tc;
   logic                step_tc;
   logic                beat_en;
   logic                step_en;
   logic                beat_gap;
   logic                step_gap;
   logic                in_gap;
   note_t               cur_code;

   // An accepted sfx_req or a falling play freezes the beat on that very cycle.
   assign beat_en = (state == MUSIC) && play && !sfx_req;
   assign step_en = (state == SFX);

   step_timer #(.CYCLES(BEAT_CYCLES), .WIDTH(BEAT_W)) u_beat_timer (
      .clk   (clk),
      .rst   (rst),
      .en    (beat_en),
      .clr   (1'b0),
      .count (beat_count),
      .tc    (beat_tc)
   );

   step_timer #(.CYCLES(STEP_CYCLES), .WIDTH(STEP_W)) u_step_timer (
      .clk   (clk),
      .rst   (rst),
      .en    (step_en),
      .clr   (!step_en),
      .count (step_count),
      .tc    (step_tc)
   );

   assign beat_gap = (BEAT_GAP != 0) && (beat_count >= BEAT_W'(BEAT_CYCLES - BEAT_GAP));
   assign step_gap = (STEP_GAP != 0) && (step_count >= STEP_W'(STEP_CYCLES - STEP_GAP));
   assign in_gap   = (state == SFX) ? step_gap : beat_gap;
   assign cur_code = (state == SFX) ? SFX_ROM[sfx_id_l][sfx_step] : MEL_ROM[mel_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mel_idx   <= '0;
         sfx_step  <= '0;
         sfx_id_l  <= '0;
         note_div  <= '0;
         amplitude <= '0;
         sfx_busy  <= 1'b0;
         beat_tick <= 1'b0;
      end else begin
         beat_tick <= beat_tc;
         if (beat_tc)
            mel_idx <= (mel_idx == 6'(MEL_LEN - 1)) ? '0 : mel_idx + 1'b1;

         case (state)
            IDLE, MUSIC: begin
               if (sfx_req) begin
                  state    <= SFX;
                  sfx_id_l <= sfx_id;
                  sfx_step <= '0;
                  sfx_busy <= 1'b1;
               end else if (state == IDLE && play) begin
                  state <= MUSIC;
               end else if (state == MUSIC && !play) begin
                  state <= IDLE;
               end
            end
            SFX: begin
               if (step_tc) begin
                  if (sfx_step == 3'(SFX_LEN - 1)) begin
                     state    <= play ? MUSIC : IDLE;
                     sfx_step <= '0;
                     sfx_busy <= 1'b0;
                  end else begin
                     sfx_step <= sfx_step + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // Rests leave note_div alone so the generator keeps its last pitch.
         if (state == IDLE) begin
            amplitude <= '0;
         end else begin
            if (cur_code != '0)
               note_div <= NOTE_DIV_LUT[cur_code];
            amplitude <= (cur_code != '0 && !mute && !in_gap) ? AMP : 16'h0000;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_music_sequencer.sv
// ============================================================================
// tb_music_sequencer : directed scoreboard bench for music_sequencer
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_music_sequencer;

   import audio_pkg::*;

   localparam int DIV_A4  = 113635;
   localparam int DIV_C5  = 95550;
   localparam int DIV_A5  = 56817;
   localparam int DIV_C6  = 47774;
   localparam int DIV_A3  = 227271;
   localparam int AMP_ON  = 32'h2000;

   typedef struct {
      int idx;
      int cyc;
   } tick_t;

   logic        clk;
   logic        rst;
   logic        play;
   logic        sfx_req;
   logic [1:0]  sfx_id;
   logic        mute;
   logic [21:0] note_div;
   logic [15:0] amplitude;
   logic        sfx_busy;
   logic        beat_tick;
   logic [5:0]  mel_idx;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   int    busy_run = 0;
   tick_t tick_q[$];
   int    sfx_q[$];
   tick_t mon_e;
   int    mon_len;
   int    t, p, t6, t7, t8, t9, t10, t12, r;

   music_sequencer #(
      .BEAT_CYCLES (16),
      .SFX_DIV     (4),
      .MEL_LEN     (4),
      .SFX_LEN     (2),
      .AMP         (16'h2000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .play      (play),
      .sfx_req   (sfx_req),
      .sfx_id    (sfx_id),
      .mute      (mute),
      .note_div  (note_div),
      .amplitude (amplitude),
      .sfx_busy  (sfx_busy),
      .beat_tick (beat_tick),
      .mel_idx   (mel_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic push_tick(input int idx, input int at);
      tick_t e;
      e.idx = idx;
      e.cyc = at;
      tick_q.push_back(e);
   endtask

   // Monitor: every beat_tick and every completed sfx_busy run is checked against the queues.
   always @(negedge clk) begin
      if (rst) begin
         busy_run = 0;
      end else begin
         if (beat_tick) begin
            if (tick_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tick_unexpected: tick with mel_idx=%0d at cycle %0d, required none", mel_idx, cyc);
            end else begin
               mon_e = tick_q.pop_front();
               check("tick_cycle", cyc, mon_e.cyc);
               check("tick_mel_idx", int'(mel_idx), mon_e.idx);
            end
         end
         if (sfx_busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            if (sfx_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sfx_unexpected: busy run of %0d cycles, required none", busy_run);
            end else begin
               mon_len = sfx_q.pop_front();
               check("sfx_busy_len", busy_run, mon_len);
            end
            busy_run = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; play = 1'b0; sfx_req = 1'b0; sfx_id = 2'd0; mute = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_note_div", int'(note_div), 0);
      check("rst_amplitude", int'(amplitude), 0);
      check("rst_sfx_busy", int'(sfx_busy), 0);
      check("rst_beat_tick", int'(beat_tick), 0);
      check("rst_mel_idx", int'(mel_idx), 0);
      check("rst_state", int'(dut.state), int'(IDLE));

      // Melody with wrap and articulation gaps
      rst = 1'b0;
      t = cyc;
      play = 1'b1;
      push_tick(1, t + 17); push_tick(2, t + 33); push_tick(3, t + 49);
      push_tick(0, t + 65); push_tick(1, t + 81); push_tick(2, t + 97);
      wait_to(t + 2);  check("b0_note_div", int'(note_div), DIV_A4);
                       check("b0_amp_on", int'(amplitude), AMP_ON);
      wait_to(t + 15); check("b0_amp_before_gap", int'(amplitude), AMP_ON);
      wait_to(t + 16); check("b0_amp_gap14", int'(amplitude), 0);
      wait_to(t + 17); check("b0_amp_gap15", int'(amplitude), 0);
      wait_to(t + 22); check("rest_amp", int'(amplitude), 0);
      wait_to(t + 34); check("b2_note_div", int'(note_div), DIV_C5);
                       check("b2_amp_on", int'(amplitude), AMP_ON);
      wait_to(t + 50); check("b3_note_div", int'(note_div), DIV_A4);
      wait_to(t + 66); check("wrap_note_div", int'(note_div), DIV_A4);

      // Pause mid-beat and resume
      t6 = t + 97;
      wait_to(t6 + 7);  play = 1'b0;
      wait_to(t6 + 20); check("pause_amp", int'(amplitude), 0);
                        check("pause_mel_idx", int'(mel_idx), 2);
      wait_to(t6 + 40); check("pause_amp_late", int'(amplitude), 0);
      wait_to(t6 + 58); play = 1'b1; p = cyc;
      push_tick(3, p + 10);

      // SFX mid-beat
      t7 = p + 10;
      wait_to(t7 + 5); sfx_req = 1'b1; sfx_id = 2'd1;
      sfx_q.push_back(8); push_tick(0, t7 + 25);
      @(negedge clk); sfx_req = 1'b0;
      wait_to(t7 + 8);  check("sfx1_step0_div", int'(note_div), DIV_A5);
                        check("sfx1_amp", int'(amplitude), AMP_ON);
                        check("sfx1_busy", int'(sfx_busy), 1);
      wait_to(t7 + 12); check("sfx1_step1_div", int'(note_div), DIV_C6);
                        check("sfx1_mel_frozen", int'(mel_idx), 3);
      wait_to(t7 + 14); check("sfx1_busy_done", int'(sfx_busy), 0);

      // SFX on the terminal-count cycle
      t8 = t7 + 25;
      wait_to(t8 + 15); sfx_req = 1'b1; sfx_id = 2'd2;
      sfx_q.push_back(8); push_tick(1, t8 + 25);
      @(negedge clk); sfx_req = 1'b0;
      wait_to(t8 + 18); check("sfx2_step0_div", int'(note_div), DIV_A3);
      wait_to(t8 + 20); check("tc_sfx_mel_hold", int'(mel_idx), 0);
                        check("tc_sfx_tick_low", int'(beat_tick), 0);

      // Retrigger ignored, then mute
      t9 = t8 + 25;
      wait_to(t9 + 2); sfx_req = 1'b1; sfx_id = 2'd1;
      sfx_q.push_back(8); push_tick(2, t9 + 25);
      @(negedge clk); sfx_req = 1'b0;
      wait_to(t9 + 5); sfx_req = 1'b1; sfx_id = 2'd2;
      @(negedge clk); sfx_req = 1'b0;
      check("retrig_step0_div", int'(note_div), DIV_A5);
      wait_to(t9 + 10); check("retrig_step1_div", int'(note_div), DIV_C6);
      t10 = t9 + 25;
      push_tick(3, t10 + 16); push_tick(0, t10 + 32); push_tick(1, t10 + 48);
      wait_to(t10 + 3);  check("premute_amp", int'(amplitude), AMP_ON);
      mute = 1'b1;
      wait_to(t10 + 4);  check("mute_amp", int'(amplitude), 0);
      wait_to(t10 + 18); check("mute_amp_next_beat", int'(amplitude), 0);
                         check("mute_mel_idx", int'(mel_idx), 3);
      mute = 1'b0;
      wait_to(t10 + 19); check("unmute_amp", int'(amplitude), AMP_ON);

      // Reset in the middle of an SFX
      t12 = t10 + 48;
      wait_to(t12 + 2); sfx_req = 1'b1; sfx_id = 2'd1;
      @(negedge clk); sfx_req = 1'b0;
      wait_to(t12 + 5); check("pre_rst_busy", int'(sfx_busy), 1);
      rst = 1'b1;
      #1;
      check("arst_sfx_busy", int'(sfx_busy), 0);
      check("arst_amplitude", int'(amplitude), 0);
      check("arst_note_div", int'(note_div), 0);
      check("arst_mel_idx", int'(mel_idx), 0);
      check("arst_beat_tick", int'(beat_tick), 0);
      check("arst_state", int'(dut.state), int'(IDLE));
      @(negedge clk);
      r = cyc;
      #2 rst = 1'b0;
      push_tick(1, r + 17);
      wait_to(r + 20);

      check("tick_queue_empty", tick_q.size(), 0);
      check("sfx_queue_empty", sfx_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
